// File: rtl/ask_pkg.sv
// Shared definitions for the 4-ASK transmit chain: bit-rate constants, symbol
// grouping and the serializer state encoding.
package ask_pkg;

    localparam int BIT_CLK_DIV_2K  = 25000;
    localparam int BITS_PER_SYMBOL = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // True when this bit index opens a new symbol pair.
    function automatic logic is_sym_first(input logic [2:0] bit_idx);
        return (bit_idx % 3'(BITS_PER_SYMBOL)) == 3'd0;
    endfunction

    function automatic logic first_bit(input logic [7:0] b, input logic msb_first);
        return msb_first ? b[7] : b[0];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with registered occupancy count; full/empty derive from
// the count register only, so they never depend combinationally on pop.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  C_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == C_FULL);
    assign empty  = (r_count == {(AW+1){1'b0}});
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Data storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count as is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/message_serializer.sv
// Byte-to-bit serializer feeding the 4-ASK modulator: fixed bit grid from a
// free-running divider, back-to-back bytes, symbol-pair marking.
module message_serializer
    import ask_pkg::*;
#(
    parameter int   CLK_DIV    = BIT_CLK_DIV_2K,
    parameter int   FIFO_DEPTH = 4,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic                         message,
    output logic                         bit_strobe,
    output logic                         sym_start,
    output logic                         busy,
    output logic                         underrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int            DW         = $clog2(CLK_DIV);
    localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_idx_nxt;
    logic          r_message;
    logic          w_msg_nxt;
    logic          r_bit_strobe;
    logic          w_strobe_nxt;
    logic          r_sym_start;
    logic          w_sym_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_underrun;
    logic          w_underrun_nxt;
    logic          r_was_send;
    logic          w_was_send_nxt;
    logic          w_tick;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_fifo_dout;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    assign w_tick     = (r_div_cnt == C_DIV_LAST);
    assign w_push     = data_valid && !w_fifo_full;
    assign data_ready = !w_fifo_full;
    assign message    = r_message;
    assign bit_strobe = r_bit_strobe;
    assign sym_start  = r_sym_start;
    assign busy       = r_busy;
    assign underrun   = r_underrun;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_fifo_dout),
        .count (fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Free-running bit-period divider; never gated so the bit grid stays fixed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= {DW{1'b0}};
        end else if (w_tick) begin
            r_div_cnt <= {DW{1'b0}};
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Next-state and next-output logic; everything only moves on a tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_idx_nxt      = r_bit_idx;
        w_msg_nxt      = r_message;
        w_strobe_nxt   = 1'b0;
        w_pop          = 1'b0;
        w_underrun_nxt = r_underrun;
        w_was_send_nxt = r_was_send;
        if (w_tick) begin
            // Remembers the state at this tick so the next idle tick can flag underrun.
            w_was_send_nxt = (r_state == SEND);
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_fifo_dout;
                        w_msg_nxt    = first_bit(w_fifo_dout, MSB_FIRST != 0);
                        w_idx_nxt    = 3'd0;
                        w_strobe_nxt = 1'b1;
                        w_state_nxt  = SEND;
                    end else begin
                        w_msg_nxt = IDLE_BIT;
                        if (r_was_send) begin
                            w_underrun_nxt = 1'b1;
                        end else begin
                            w_underrun_nxt = r_underrun;
                        end
                    end
                end
                SEND: begin
                    if (r_bit_idx != 3'd7) begin
                        w_shift_nxt  = (MSB_FIRST != 0) ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
                        w_msg_nxt    = (MSB_FIRST != 0) ? r_shift[6] : r_shift[1];
                        w_idx_nxt    = r_bit_idx + 3'd1;
                        w_strobe_nxt = 1'b1;
                    end else if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_fifo_dout;
                        w_msg_nxt    = first_bit(w_fifo_dout, MSB_FIRST != 0);
                        w_idx_nxt    = 3'd0;
                        w_strobe_nxt = 1'b1;
                    end else begin
                        w_msg_nxt   = IDLE_BIT;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_msg_nxt   = IDLE_BIT;
                    w_state_nxt = IDLE;
                end
            endcase
        end else begin
            w_strobe_nxt = 1'b0;
        end
        w_busy_nxt = (w_state_nxt == SEND);
        w_sym_nxt  = w_busy_nxt && is_sym_first(w_idx_nxt);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shift      <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_message    <= IDLE_BIT;
            r_bit_strobe <= 1'b0;
            r_sym_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_underrun   <= 1'b0;
            r_was_send   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_idx    <= w_idx_nxt;
            r_message    <= w_msg_nxt;
            r_bit_strobe <= w_strobe_nxt;
            r_sym_start  <= w_sym_nxt;
            r_busy       <= w_busy_nxt;
            r_underrun   <= w_underrun_nxt;
            r_was_send   <= w_was_send_nxt;
        end
    end

endmodule

// File: tb/tb_message_serializer.sv
// Self-checking bench for message_serializer: bit-stream scoreboard, vector
// table across both bit orders, and directed multi-cycle corner cases.
module tb_message_serializer;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in, data_in_l;
    logic       data_valid, data_valid_l;
    logic       data_ready, message, bit_strobe, sym_start, busy, underrun;
    logic       data_ready_l, message_l, bit_strobe_l, sym_start_l, busy_l, underrun_l;
    logic [2:0] fifo_count, fifo_count_l;

    always #5 clk = ~clk;

    message_serializer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .message(message), .bit_strobe(bit_strobe), .sym_start(sym_start), .busy(busy),
        .underrun(underrun), .fifo_count(fifo_count));

    message_serializer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in_l), .data_valid(data_valid_l), .data_ready(data_ready_l),
        .message(message_l), .bit_strobe(bit_strobe_l), .sym_start(sym_start_l), .busy(busy_l),
        .underrun(underrun_l), .fifo_count(fifo_count_l));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted bytes become an ordered stream of expected bits.
    bit   exp_bits[$];
    int   pushes = 0, started = 0, pos = 0, cyc = 0, last_strobe_cyc = 0;
    bit   in_run = 1'b0, saw_full = 1'b0;
    logic last_msg = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst && data_valid && data_ready) begin
            for (int j = 0; j < 8; j++) exp_bits.push_back(data_in[7-j]);
            pushes++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (!data_ready) saw_full = 1'b1;
            if (bit_strobe) begin
                if (exp_bits.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bit actual=strobe expected=no_strobe at %0t", $time);
                end else begin
                    check("stream_bit", message, exp_bits.pop_front());
                end
                check("sym_start", sym_start, (pos % 2) == 0);
                check("busy_on_bit", busy, 1'b1);
                if (pos == 0) started++;
                if (in_run) check("bit_period", cyc - last_strobe_cyc, CLK_DIV);
                last_strobe_cyc = cyc;
                last_msg        = message;
                in_run          = 1'b1;
                pos             = (pos + 1) % 8;
            end else if (busy && in_run) begin
                check("bit_hold", message, last_msg);
            end else begin
                check("idle_level", message, 1'b0);
                check("idle_sym", sym_start, 1'b0);
                in_run = 1'b0;
            end
            check("fifo_count", fifo_count, pushes - started);
            check("data_ready", data_ready, (pushes - started) != DEPTH);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        data_valid = 1'b0; data_valid_l = 1'b0;
        exp_bits.delete();
        pushes = 0; started = 0; pos = 0; in_run = 1'b0;
        #1;
        check("rst_message", message, 1'b0);
        check("rst_strobe", bit_strobe, 1'b0);
        check("rst_sym", sym_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_ready", data_ready, 1'b1);
        check("rst_message_lsb", message_l, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit hold);
        int n = 0;
        @(negedge clk);
        data_in = b; data_valid = 1'b1;
        while (!data_ready && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=not_ready expected=ready at %0t", $time);
        end
        @(posedge clk);
        #1 if (!hold) data_valid = 1'b0;
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bit_strobe && n < 200);
        if (!bit_strobe) begin
            checks++; errors++;
            $display("FAIL strobe_timeout actual=0 expected=1 at %0t", $time);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_bits.size() != 0 || busy || busy_l) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=busy expected=idle at %0t", $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_msb;   // first bit on message in [7]
        logic [7:0] exp_lsb;
        logic [7:0] exp_sym;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  seq_m, seq_l, syms;
        logic [15:0] bits16;
        int nb, busy_cyc, drop, lsb_miss, strobes;
        int gaps[40];

        vecs[0] = '{8'hB4, 8'hB4, 8'b0010_1101, 8'hAA};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF,        8'hAA};
        vecs[2] = '{8'h00, 8'h00, 8'h00,        8'hAA};
        vecs[3] = '{8'h01, 8'h01, 8'b1000_0000, 8'hAA};
        vecs[4] = '{8'hA5, 8'hA5, 8'b1010_0101, 8'hAA};
        vecs[5] = '{8'h3C, 8'h3C, 8'b0011_1100, 8'hAA};

        rst = 1'b0; data_in = 8'h00; data_in_l = 8'h00; data_valid = 1'b0; data_valid_l = 1'b0;
        do_reset();

        // Vector table: both bit orders side by side.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            data_in = vecs[v].data; data_in_l = vecs[v].data;
            data_valid = 1'b1; data_valid_l = 1'b1;
            @(posedge clk);
            #1 data_valid = 1'b0; data_valid_l = 1'b0;
            lsb_miss = 0;
            for (int k = 0; k < 8; k++) begin
                wait_strobe();
                seq_m[7-k] = message; seq_l[7-k] = message_l; syms[7-k] = sym_start;
                if (!bit_strobe_l) lsb_miss++;
            end
            check("vec_msb_seq", seq_m, vecs[v].exp_msb);
            check("vec_lsb_seq", seq_l, vecs[v].exp_lsb);
            check("vec_sym", syms, vecs[v].exp_sym);
            check("vec_lsb_strobe", lsb_miss, 0);
            wait_drain();
        end

        // Single byte: bit values, busy length, underrun one tick later.
        do_reset();
        push_byte(8'hB4, 1'b0);
        wait_strobe();
        nb = 0; busy_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            busy_cyc++;
            if (bit_strobe && nb < 8) begin seq_m[7-nb] = message; syms[7-nb] = sym_start; nb++; end
            @(negedge clk);
        end
        check("single_bits", seq_m, 8'b1011_0100);
        check("single_sym", syms, 8'b1010_1010);
        check("single_nbits", nb, 8);
        check("single_busy_cycles", busy_cyc, 32);
        check("underrun_at_fall", underrun, 1'b0);
        repeat (3) @(negedge clk);
        check("underrun_before_tick", underrun, 1'b0);
        @(negedge clk);
        check("underrun_after_tick", underrun, 1'b1);

        // Back-to-back bytes with no gap bit.
        do_reset();
        push_byte(8'hFF, 1'b1);
        push_byte(8'h00, 1'b0);
        wait_strobe();
        bits16 = 16'h0000; bits16[15] = message; nb = 1; drop = 0;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (!busy) drop++;
            if (bit_strobe && nb < 16) begin bits16[15-nb] = message; nb++; end
        end
        check("b2b_bits", bits16, 16'hFF00);
        check("b2b_nbits", nb, 16);
        check("b2b_busy_gap", drop, 0);
        wait_drain();

        // Back-pressure: six bytes with valid held.
        do_reset();
        saw_full = 1'b0;
        push_byte(8'h11, 1'b1); push_byte(8'h22, 1'b1); push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1); push_byte(8'h55, 1'b1); push_byte(8'h66, 1'b0);
        wait_drain();
        check("bp_saw_full", saw_full, 1'b1);
        check("bp_pushes", pushes, 6);
        check("bp_started", started, 6);

        // Push on the tick cycle into an empty idle FIFO.
        do_reset();
        push_byte(8'h5A, 1'b0);
        wait_drain();                         // first cycle after the tick that ended the byte
        check("tick_underrun_pre", underrun, 1'b0);
        repeat (3) @(negedge clk);            // tick cycle
        data_in = 8'h80; data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        @(negedge clk);
        check("tick_push_msg", message, 1'b0);
        check("tick_push_busy", busy, 1'b0);
        check("tick_push_count", fifo_count, 3'd1);
        check("tick_push_underrun", underrun, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tick_push_wait", {busy, message, bit_strobe}, 3'b000);
        end
        @(negedge clk);
        check("tick_push_launch", {busy, message, bit_strobe}, 3'b111);
        wait_drain();

        // Reset mid-byte with bytes still queued.
        do_reset();
        push_byte(8'hFF, 1'b1); push_byte(8'hAA, 1'b1); push_byte(8'h55, 1'b0);
        nb = 0;
        while (!(message && fifo_count == 3'd2) && nb < 100) begin @(negedge clk); nb++; end
        check("pre_reset_state", {message, fifo_count}, {1'b1, 3'd2});
        do_reset();
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bit_strobe || busy) strobes++;
        end
        check("post_reset_quiet", strobes, 0);
        check("post_reset_count", fifo_count, 3'd0);

        // Randomised traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 40; i++) gaps[i] = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 40);
        for (int i = 0; i < 40; i++) begin
            repeat (gaps[i]) @(negedge clk);
            push_byte(8'($urandom), (i < 39) && (gaps[i+1] == 0));
        end
        wait_drain();
        check("rand_all_sent", started, pushes);
        check("rand_pushes", pushes, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_serializer.md
# message_serializer

Upstream stage of the 4-ASK modulator. Accepts bytes from a host over a valid/ready handshake, buffers them in a small FIFO, and emits them one bit at a time on `message` at a fixed bit rate derived from `clk` (default 2 kHz from 50 MHz). Bits are grouped into aligned 2-bit symbol pairs so the modulator sees consistent symbol boundaries. `sym_start` marks the first bit of each pair.

## Interface
- `CLK_DIV`, 25000: bit period in `clk` cycles; ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit 7 first, 0 sends bit 0 first.
- `IDLE_BIT`, 0: level driven on `message` when no data is being sent.

Ports:
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_ready`  out  1  FIFO can accept a byte; a byte transfers on the rising edge where `data_valid` and `data_ready` are both 1.
- `message`  out  1  serial bit to the 4-ASK modulator; registered.
- `bit_strobe`  out  1  one-cycle pulse on the cycle `message` takes a new bit period.
- `sym_start`  out  1  high for the whole bit period of the first bit of each 2-bit symbol.
- `busy`  out  1  a byte is being shifted out.
- `underrun`  out  1  sticky flag: a tick occurred mid-idle after a transmission ended with the FIFO empty. Cleared only by reset.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.

## Operation
- **Bit-rate counter.** `div_cnt` counts 0 to CLK_DIV-1 and wraps. It runs continuously out of reset, so the bit grid never drifts. A tick occurs on the cycle `div_cnt == CLK_DIV-1`.
- **FIFO.** Circular buffer with read and write pointers plus a count.
  - `data_ready = (fifo_count != FIFO_DEPTH)`; it is driven from registered count only, with no combinational path from pop.
  - A push and a pop in the same cycle leave the count unchanged.
  - A write while full cannot occur, because `data_ready` is low.
- **State machine, IDLE state.**
  - `message = IDLE_BIT`, `busy = 0`, `sym_start = 0`.
  - On a tick with the FIFO non-empty: pop a byte into the 8-bit shift register, drive its first bit, set `bit_idx = 0`, and go to SEND.
  - On a tick with the FIFO empty: stay in IDLE. If the previous state was SEND, set `underrun`.
- **State machine, SEND state.** `busy = 1`. On each tick:
  - If `bit_idx < 7`: shift and output the next bit; `bit_idx` increments.
  - If `bit_idx == 7` and the FIFO is non-empty: pop and load the next byte back-to-back, with no gap bit.
  - If `bit_idx == 7` and the FIFO is empty: return to IDLE and drive IDLE_BIT.
- **Outputs on a tick.**
  - `bit_strobe` pulses on every tick where a data bit is launched.
  - `sym_start = 1` for bit periods where `bit_idx` is even (0, 2, 4, 6). Each byte therefore forms 4 symbols.
- **Bit order.** MSB_FIRST selects left shift with output bit 7, or right shift with output bit 0.

## Timing
- **Reset values** (async assert, synchronous release on the next `clk` edge):
  - `message = IDLE_BIT`; `bit_strobe`, `sym_start`, `busy`, `underrun` = 0.
  - `fifo_count = 0`; `data_ready = 1`.
  - `div_cnt = 0`, state IDLE.
- **Reset mid-byte.** Aborts immediately. FIFO contents are discarded, and the partial byte is not resumed.
- **Latency.** A byte pushed into an empty, idle block appears at the next tick, between 1 and CLK_DIV cycles later. `message`, `sym_start`, `busy` and `bit_strobe` all change on the clock edge that ends the tick cycle.
- **Push on a tick cycle.** A byte pushed on the same cycle as a tick, into an empty FIFO in IDLE, is not seen by that tick. It is launched at the following tick.
- **Bit duration.** Each bit is held exactly CLK_DIV cycles. A byte occupies 8·CLK_DIV cycles.
- **FIFO full.** `data_ready` falls on the edge that makes `fifo_count == FIFO_DEPTH`. It rises on the edge after the pop.

## Structure
- Shared package `ask_pkg`:
  - `BIT_CLK_DIV_2K = 25000`.
  - `BITS_PER_SYMBOL = 2`.
  - state enum `{IDLE, SEND}`.
  - Also used by Four_ASK.
- One sub-module `byte_fifo` (parameter DEPTH; ports push, pop, din, dout, count, full, empty), kept in its own file.
- The divider, shift register and FSM stay in the top module.

## Test plan
All scenarios use CLK_DIV = 4 and FIFO_DEPTH = 4.
- **Reset.** Assert `rst = 0` mid-run with `message = 1` and 2 bytes queued → all outputs go to reset values in the same cycle, `fifo_count = 0`, `data_ready = 1`.
- **Single byte, MSB first.** Push 8'hB4 → `message` reads 1,0,1,1,0,1,0,0, each held 4 cycles. `sym_start` is high on bits 1, 3, 5 and 7 of the sequence. `busy` falls after 32 cycles, and `underrun` sets at the following tick.
- **Back-to-back.** Push 8'hFF then 8'h00 → 16 contiguous bit periods with no idle bit between them, 8 ones then 8 zeros, and `busy` stays high throughout.
- **Back-pressure.** Hold `data_valid = 1` with 6 distinct bytes → `data_ready` drops when `fifo_count = 4`. All 6 bytes emerge in order with none lost or duplicated.
- **LSB first.** Set MSB_FIRST = 0 and push 8'h01 → the first bit is 1, followed by seven 0s.
- **Tick-cycle push.** Push while `div_cnt == 3` in IDLE with the FIFO empty → `message` remains IDLE_BIT at that tick, and the first bit appears 4 cycles later.
